busarb: RTL
===========

# busarb

Round-robin arbiter that shares one strobe/ack register bus (the busmux register-file bus) between NREQ requesters. Each requester presents a level request with write-enable, 8-bit address and write data. The arbiter issues exactly one single-cycle strobe per granted transaction, waits for the bus ack or a timeout, and returns a one-cycle ack (plus error flag) and read data to the winner. It sits between the host-side masters (CPU bridge, debug port, DMA) and the busmux slave.

## Interface
- DATAW, 8, data width of bus and requesters
- NREQ, 3, number of requesters (2..8)
- TIMEOUT, 16, maximum WAIT cycles before a transaction is failed (>=4)

- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_req  in  NREQ  per-requester request, held high until its o_ack
- i_we  in  NREQ  per-requester write enable
- i_addr  in  8*NREQ  packed addresses, requester k at [8k+7:8k]
- i_data  in  DATAW*NREQ  packed write data, requester k at [DATAW*k+DATAW-1:DATAW*k]
- o_ack  out  NREQ  one-cycle completion pulse to granted requester
- o_err  out  NREQ  qualifies o_ack: 1 = timed out
- o_data  out  DATAW  read data, valid only while any o_ack bit is high
- o_busy  out  1  high in every state except IDLE
- o_stb  out  1  bus strobe, one cycle per transaction
- o_we  out  1  bus write enable
- o_addr  out  8  bus address, held stable STB through RESP
- o_wdata  out  DATAW  bus write data, held stable STB through RESP
- i_ack  in  1  bus ack from slave
- i_rdata  in  DATAW  bus read data, sampled when i_ack is high

## Operation
- Reset (i_rst_n low, async): state IDLE; all outputs 0; last-grant pointer = NREQ-1, so requester 0 has top priority after reset.
- States: IDLE, STB, WAIT, RESP.
- IDLE: if i_req != 0, pick the winner by searching from (last+1) mod NREQ upward with wrap. Latch that winner's we/addr/data into o_we/o_addr/o_wdata, store the grant index, update last := winner, go STB. Otherwise stay in IDLE.
- STB: o_stb=1 for this cycle only. Clear the timeout counter. Go WAIT.
- WAIT: if i_ack, capture i_rdata into a data register, clear the error flag, go RESP. Else if counter == TIMEOUT-1, set data register to all-ones, set the error flag, go RESP. Else counter++.
- RESP: o_ack[grant]=1, o_err[grant]=error flag, o_data=data register. All other o_ack/o_err bits are 0. Go IDLE.
- o_data is 0 outside RESP.
- o_addr/o_wdata/o_we keep their last values in IDLE. They change only on a grant.
- i_ack outside WAIT (a late ack after a timeout, or a spurious ack) is ignored and has no effect.
- The requester must deassert i_req[k] in the cycle after its o_ack[k], unless it is issuing a new transaction. A re-request from the same requester competes normally and is lowest priority.
- Changes to i_we/i_addr/i_data of a granted requester after the grant cycle have no effect.
- Timeout counter width is clog2(TIMEOUT). It never wraps, because it is compared before incrementing.

## Timing
- Grant decision at cycle 0 (IDLE with a request). o_stb at cycle 1. WAIT from cycle 2.
- With busmux (ack 2 cycles after stb): i_ack at cycle 3, o_ack at cycle 4. Request-to-ack latency is 4 cycles.
- Back-to-back: next grant decision at cycle 5. Sustained throughput is one transaction per 5 cycles.
- Timeout path: WAIT lasts exactly TIMEOUT cycles, so o_ack comes TIMEOUT+2 cycles after the grant decision.
- Simultaneous i_ack and counter == TIMEOUT-1: the ack wins and o_err=0.
- Reset asserted mid-transaction: everything returns to reset values immediately. No o_ack is produced for the aborted transaction.

## Test plan
- Single read: reset, then i_req=3'b010, addr 0x12, i_we=0. Slave acks 2 cycles after o_stb with rdata 0xA5. Required: o_stb at cycle 1 with o_addr=0x12; o_ack=3'b010, o_err=0, o_data=0xA5 at cycle 4.
- Round-robin fairness: all three requesters held high continuously, re-requesting after each ack. Required grant order 0,1,2,0,1,2, and exactly one o_stb per transaction.
- Write pass-through: requester 2 writes 0x3C to addr 0x21. Required: o_we=1, o_wdata=0x3C, o_addr=0x21 during o_stb; o_ack[2] pulses. A following read of 0x21 through busmux returns 0x3C.
- Timeout: TIMEOUT=16, slave never acks. Required: o_ack[0]=1, o_err[0]=1, o_data=0xFF at cycle 18. A late i_ack at cycle 20 is ignored, with no extra o_ack.
- Ack at boundary: i_ack arrives in the last WAIT cycle (counter=15). Required: o_err=0 and o_data equals rdata.
- Async reset mid-WAIT: drop i_rst_n in WAIT without any clock edge. Required: o_busy, o_stb and o_ack go 0 immediately. After release, requester 0 wins first.

Source files
------------

// File: rtl/busarb_if.sv
// Requester-side and register-bus signals of the round-robin bus arbiter.
// The arbiter takes the master view; the requesters and the bus slave take the slave view.
interface busarb_if #(
    parameter int DATAW = 8,
    parameter int NREQ  = 3
);
    logic [NREQ-1:0]       i_req;
    logic [NREQ-1:0]       i_we;
    logic [8*NREQ-1:0]     i_addr;
    logic [DATAW*NREQ-1:0] i_data;
    logic [NREQ-1:0]       o_ack;
    logic [NREQ-1:0]       o_err;
    logic [DATAW-1:0]      o_data;
    logic                  o_busy;
    logic                  o_stb;
    logic                  o_we;
    logic [7:0]            o_addr;
    logic [DATAW-1:0]      o_wdata;
    logic                  i_ack;
    logic [DATAW-1:0]      i_rdata;

    modport master (
        input  i_req, i_we, i_addr, i_data, i_ack, i_rdata,
        output o_ack, o_err, o_data, o_busy, o_stb, o_we, o_addr, o_wdata
    );

    modport slave (
        output i_req, i_we, i_addr, i_data, i_ack, i_rdata,
        input  o_ack, o_err, o_data, o_busy, o_stb, o_we, o_addr, o_wdata
    );
endinterface

// File: rtl/busarb.sv
// Round-robin arbiter sharing one strobe/ack register bus between NREQ requesters,
// with a per-transaction timeout that returns all-ones data and an error flag.
module busarb #(
    parameter int DATAW   = 8,
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    busarb_if.master bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, STB, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   last, grant, win, cand;
    logic              found;
    logic [CNTW-1:0]   cnt;
    logic              tmo;
    logic              we_r, err_r;
    logic [7:0]        addr_r;
    logic [DATAW-1:0]  wdata_r, data_r;
    logic [NREQ-1:0]   ack_v, err_v;
    logic [DATAW-1:0]  odata_v;
    logic              stb_v, busy_v;

    // Compared before incrementing, so the counter never wraps.
    assign tmo = (cnt == CNTW'(TIMEOUT - 1));

    // Search starts just past the last winner, so a re-request ranks lowest.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int o = 1; o <= NREQ; o++) begin
            cand = IDXW'((int'(last) + o) % NREQ);
            if (!found && bus.i_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = STB;
            STB:     state_nxt = WAIT;
            WAIT:    if (bus.i_ack || tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields are captured only on a grant, so requester changes afterwards are invisible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last    <= IDXW'(NREQ - 1);
            grant   <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            cnt     <= '0;
            data_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant   <= win;
                    last    <= win;
                    we_r    <= bus.i_we[win];
                    addr_r  <= bus.i_addr[int'(win)*8 +: 8];
                    wdata_r <= bus.i_data[int'(win)*DATAW +: DATAW];
                end
                STB: cnt <= '0;
                WAIT: begin
                    if (bus.i_ack) begin
                        data_r <= bus.i_rdata;
                        err_r  <= 1'b0;
                    end else if (tmo) begin
                        data_r <= '1;
                        err_r  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack_v   = '0;
        err_v   = '0;
        odata_v = '0;
        stb_v   = (state == STB);
        busy_v  = (state != IDLE);
        if (state == RESP) begin
            ack_v[grant] = 1'b1;
            err_v[grant] = err_r;
            odata_v      = data_r;
        end
    end

    assign bus.o_ack   = ack_v;
    assign bus.o_err   = err_v;
    assign bus.o_data  = odata_v;
    assign bus.o_stb   = stb_v;
    assign bus.o_busy  = busy_v;
    assign bus.o_we    = we_r;
    assign bus.o_addr  = addr_r;
    assign bus.o_wdata = wdata_r;
endmodule
